uart_rx: RTL

UART receive engine: recovers 8N1 frames from the asynchronous serial line `rx` and presents each byte on a valid/ready output. It consumes a single-cycle oversample tick from a `baud_gen` instance configured at `BAUD_RATE*OVERSAMPLE`. It is the receive-side counterpart of the tick generator and sits between the pad and the byte-level consumer (FIFO or register block).

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous input, then re-register to let metastability settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receive engine: oversampled start/data/stop recovery with a
// valid/ready byte output and one-cycle frame-error / overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Mid start bit is half a bit period in; data/stop sample one full period later.
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_sync_s;
    logic                 fall_s;
    logic [CW-1:0]        cnt_next_s;

    uart_state_e          state_q;
    logic                 rx_prev_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_sync_s)
    );

    // Falling edge only when the line was seen high first, so a stuck-low line never re-arms.
    assign fall_s     = rx_prev_q & ~rx_sync_s;
    assign cnt_next_s = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    // Previous synced line value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_sync_s;
        end
    end

    // Frame FSM with sample counter, shift register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // Consumer handshake; a completing frame below may re-set valid in the same cycle.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (fall_s) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (cnt_q == CNT_MID) begin
                            cnt_q <= '0;
                            if (!rx_sync_s) begin
                                bit_idx_q <= '0;
                                state_q   <= DATA;
                            end else begin
                                // Glitch shorter than half a bit: false start.
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_q <= cnt_next_s;
                        if (cnt_q == CNT_LAST) begin
                            // LSB arrives first, so shift in from the top.
                            shift_q <= {rx_sync_s, shift_q[DATA_BITS-1:1]};
                            if (bit_idx_q == BIT_LAST) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt_q <= cnt_next_s;
                        if (cnt_q == CNT_LAST) begin
                            if (rx_sync_s) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                                // Overwriting only counts as overrun if the old byte is not taken now.
                                overrun_q  <= rx_valid_q & ~rx_ready;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
